ser_sum_collector: RTL

//   Downstream stage of the serial adder. Captures the LSB-first serial sum stream into a

---
 rtl/ser_sum_collector.sv | 108 ++++++++++
 1 files changed

// File: rtl/ser_sum_collector.sv
// ser_sum_collector
//   Downstream stage of the serial adder. Collects the LSB-first serial sum
//   stream into a WIDTH-bit word and hands it to a parallel consumer through
//   a valid/ready handshake. The result register is separate from the
//   collection shift register, so a new add can run while the previous word
//   waits for the consumer.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | no word in progress; bit_cnt holds its last value
//   SKIPPING | discarding SKIP shift cycles of adder pipeline slack
//   COLLECT  | shifting sum bits into shreg, LSB first
//
// Ports
//   clk           rising-edge clock, shared with the adder
//   reset         synchronous active-high reset, overrides all inputs
//   mode          1 = adder load cycle (start word), 0 = shift cycle
//   sum           serial sum bit, LSB first
//   result        assembled word, stable while result_valid is high
//   result_valid  result holds an unconsumed word
//   result_ready  consumer accepts result when high with result_valid
//   busy          collection in progress (SKIPPING or COLLECT)
//   bit_cnt       bits captured in the current word (0..WIDTH)
//   overrun       sticky: an unconsumed result was overwritten
module ser_sum_collector #(
  parameter int WIDTH = 16,
  parameter int SKIP  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mode,
  input  logic                       sum,
  output logic [WIDTH-1:0]           result,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       overrun
);

  localparam int CW  = $clog2(WIDTH + 1);
  // Keep the skip counter at least one bit wide so SKIP=0 still elaborates.
  localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  localparam logic [CW-1:0]  LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP > 0) ? SKIP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SKIPPING = 2'd1,
    COLLECT  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [SKW-1:0]   skip_cnt;
  logic [WIDTH-1:0] next_word;
  logic             completion;

  assign next_word  = {sum, shreg[WIDTH-1:1]};
  assign completion = !mode && (state == COLLECT) && (bit_cnt == LAST_BIT);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      skip_cnt     <= '0;
      bit_cnt      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (mode) begin
        // A load restarts collection from any state; a partial word is dropped.
        shreg    <= '0;
        bit_cnt  <= '0;
        skip_cnt <= '0;
        state    <= (SKIP > 0) ? SKIPPING : COLLECT;
      end else begin
        case (state)
          IDLE: ;
          SKIPPING: begin
            skip_cnt <= skip_cnt + 1'b1;
            if (skip_cnt == SKIP_LAST) state <= COLLECT;
          end
          COLLECT: begin
            shreg   <= next_word;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

      // A completion wins over a transfer: the new word replaces the one being
      // taken, so valid stays high. Overrun only flags a word lost untaken.
      if (completion) begin
        result       <= next_word;
        result_valid <= 1'b1;
        if (result_valid && !result_ready) overrun <= 1'b1;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule
